// File: rtl/cobra_bus_pkg.sv
// Shared types, constants and the address decoder for the cobra bus controller.
package cobra_bus_pkg;

    typedef enum logic [2:0] {
        BUS_IDLE,
        BUS_MEM,
        BUS_WAITCNT,
        BUS_IO,
        BUS_DONE
    } bus_state_t;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_RD,
        ACC_WR
    } acc_t;

    typedef enum logic [1:0] {
        REG_ROM,
        REG_RAM,
        REG_NONE
    } region_t;

    localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;

    // ROM wins over RAM so a ROM_BITS of 16 still decodes sensibly.
    function automatic region_t decode_region(input logic [15:0] addr, input int rom_bits);
        if ({16'd0, addr} < (32'd1 << rom_bits)) return REG_ROM;
        if (addr[15]) return REG_RAM;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/frame_int_gen.sv
// Free-running frame counter that raises a bounded, acknowledgeable int_n pulse.
module frame_int_gen #(
    parameter int INT_PERIOD = 40000,
    parameter int INT_WIDTH  = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic intcycle_n,
    output logic int_n
);

    localparam int CW = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
    localparam int WW = $clog2(INT_WIDTH + 1);

    logic [CW-1:0] period_cnt;
    logic [WW-1:0] width_cnt;
    logic          period_hit;

    assign period_hit = (period_cnt == CW'(INT_PERIOD - 1));

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
            width_cnt  <= '0;
            int_n      <= 1'b1;
        end else begin
            period_cnt <= period_hit ? '0 : period_cnt + CW'(1);
            // A period boundary during an active pulse is ignored, so the pulse never stretches.
            if (!int_n) begin
                if (!intcycle_n || width_cnt == WW'(INT_WIDTH - 1)) begin
                    int_n <= 1'b1;
                end else begin
                    width_cnt <= width_cnt + WW'(1);
                end
            end else if (period_hit) begin
                int_n     <= 1'b0;
                width_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/z80_bus_ctrl.sv
// Turns tv80 T1 cycles into ROM, RAM or I/O accesses, stretches them with wait_n
// and returns read data on di/dinst; also hosts the frame interrupt generator.
module z80_bus_ctrl
    import cobra_bus_pkg::*;
#(
    parameter int ROM_BITS   = 11,
    parameter int MEM_WAIT   = 1,
    parameter int IO_TIMEOUT = 15,
    parameter int INT_PERIOD = 40000,
    parameter int INT_WIDTH  = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          ts,
    input  logic                iorq,
    input  logic                no_read,
    input  logic                write,
    input  logic                rfsh_n,
    input  logic                intcycle_n,
    input  logic [15:0]         A,
    input  logic [7:0]          dout,
    output logic [7:0]          di,
    output logic [7:0]          dinst,
    output logic                wait_n,
    output logic                int_n,
    output logic [ROM_BITS-1:0] rom_addr,
    input  logic [7:0]          rom_rdata,
    output logic [14:0]         ram_addr,
    output logic                ram_we,
    output logic [7:0]          ram_wdata,
    input  logic [7:0]          ram_rdata,
    output logic [7:0]          io_addr,
    output logic                io_rd,
    output logic                io_wr,
    output logic [7:0]          io_wdata,
    input  logic [7:0]          io_rdata,
    input  logic                io_ready
);

    bus_state_t state;
    acc_t       acc;
    region_t    region;
    logic       is_io;
    logic [2:0] wait_cnt;
    logic [3:0] io_cnt;

    logic       req;
    acc_t       req_acc;
    region_t    req_region;
    logic [7:0] mem_rdata;
    logic       unused_ts;

    assign unused_ts = ^ts[6:1];
    assign dinst     = di;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        req        = ts[0] && rfsh_n && intcycle_n;
        req_acc    = ACC_NONE;
        req_region = decode_region(A, ROM_BITS);
        if (iorq) begin
            req_acc = write ? ACC_WR : ACC_RD;
        end else if (write) begin
            req_acc = ACC_WR;
        end else if (!no_read) begin
            req_acc = ACC_RD;
        end
    end

    always_comb begin
        mem_rdata = BUS_IDLE_DATA;
        case (region)
            REG_ROM: mem_rdata = rom_rdata;
            REG_RAM: mem_rdata = ram_rdata;
            default: mem_rdata = BUS_IDLE_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BUS_IDLE;
            acc       <= ACC_NONE;
            region    <= REG_NONE;
            is_io     <= 1'b0;
            wait_cnt  <= '0;
            io_cnt    <= '0;
            di        <= BUS_IDLE_DATA;
            wait_n    <= 1'b1;
            rom_addr  <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            io_addr   <= '0;
            io_rd     <= 1'b0;
            io_wr     <= 1'b0;
            io_wdata  <= '0;
        end else begin
            case (state)
                BUS_IDLE: begin
                    if (req && req_acc != ACC_NONE) begin
                        acc    <= req_acc;
                        wait_n <= 1'b0;
                        if (iorq) begin
                            state    <= BUS_IO;
                            is_io    <= 1'b1;
                            region   <= REG_NONE;
                            io_cnt   <= '0;
                            io_addr  <= A[7:0];
                            io_wdata <= dout;
                            io_rd    <= (req_acc == ACC_RD);
                            io_wr    <= (req_acc == ACC_WR);
                        end else begin
                            state     <= BUS_MEM;
                            is_io     <= 1'b0;
                            region    <= req_region;
                            rom_addr  <= A[ROM_BITS-1:0];
                            ram_addr  <= A[14:0];
                            ram_wdata <= dout;
                            // Writes to ROM or the unmapped hole never reach a strobe.
                            ram_we    <= (req_acc == ACC_WR) && (req_region == REG_RAM);
                        end
                    end
                end
                BUS_MEM: begin
                    ram_we <= 1'b0;
                    if (region == REG_RAM && MEM_WAIT > 0) begin
                        state    <= BUS_WAITCNT;
                        wait_cnt <= 3'(MEM_WAIT - 1);
                    end else begin
                        state <= BUS_DONE;
                    end
                end
                BUS_WAITCNT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= BUS_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                BUS_IO: begin
                    if (io_ready || io_cnt == 4'(IO_TIMEOUT - 1)) begin
                        state <= BUS_DONE;
                        io_rd <= 1'b0;
                        io_wr <= 1'b0;
                        if (acc == ACC_RD) begin
                            di <= io_ready ? io_rdata : BUS_IDLE_DATA;
                        end
                    end else if (io_cnt != 4'hF) begin
                        io_cnt <= io_cnt + 4'd1;
                    end
                end
                BUS_DONE: begin
                    state  <= BUS_IDLE;
                    wait_n <= 1'b1;
                    if (!is_io && acc == ACC_RD) begin
                        di <= mem_rdata;
                    end
                end
                default: state <= BUS_IDLE;
            endcase
        end
    end

    frame_int_gen #(
        .INT_PERIOD(INT_PERIOD),
        .INT_WIDTH (INT_WIDTH)
    ) u_frame_int (
        .clk       (clk),
        .reset     (reset),
        .intcycle_n(intcycle_n),
        .int_n     (int_n)
    );

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Scoreboard bench for z80_bus_ctrl: random bus traffic plus a cycle-level interrupt model.
module tb_z80_bus_ctrl;

    localparam int ROM_BITS   = 11;
    localparam int MEM_WAIT   = 2;
    localparam int IO_TIMEOUT = 15;
    localparam int INT_PERIOD = 100;
    localparam int INT_WIDTH  = 10;
    localparam int ACK_CYC    = 204;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  ts = 7'd0;
    logic        iorq = 1'b0, no_read = 1'b1, write = 1'b0, rfsh_n = 1'b1, intcycle_n = 1'b1;
    logic [15:0] A = 16'd0;
    logic [7:0]  dout = 8'd0;
    logic [7:0]  di, dinst;
    logic        wait_n, int_n;
    logic [ROM_BITS-1:0] rom_addr;
    logic [7:0]  rom_rdata = 8'd0;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'd0;
    logic [7:0]  io_addr;
    logic        io_rd, io_wr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata = 8'd0;
    logic        io_ready = 1'b0;

    z80_bus_ctrl #(
        .ROM_BITS(ROM_BITS), .MEM_WAIT(MEM_WAIT), .IO_TIMEOUT(IO_TIMEOUT),
        .INT_PERIOD(INT_PERIOD), .INT_WIDTH(INT_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .ts(ts), .iorq(iorq), .no_read(no_read), .write(write),
        .rfsh_n(rfsh_n), .intcycle_n(intcycle_n), .A(A), .dout(dout), .di(di), .dinst(dinst),
        .wait_n(wait_n), .int_n(int_n), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ready(io_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] di;
        int         low;
        int         we;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic ack_enable = 1'b1;

    logic [7:0] rom_img [2**ROM_BITS];
    logic [7:0] ram_env [32768];
    logic [7:0] ram_ref [32768];
    logic [7:0] model_di = 8'hFF;

    int         io_delay = 0;
    logic [7:0] io_resp_data = 8'd0;
    logic [7:0] exp_io_addr = 8'd0, exp_io_wdata = 8'd0;
    logic       exp_io_wr = 1'b0;
    int         io_strobe_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory models: synchronous, one cycle of read latency, write-first RAM.
    always @(posedge clk) begin
        rom_rdata <= rom_img[rom_addr];
        if (ram_we) begin
            ram_env[ram_addr] <= ram_wdata;
            ram_rdata         <= ram_wdata;
        end else begin
            ram_rdata <= ram_env[ram_addr];
        end
    end

    // I/O responder: answers after io_delay strobe cycles, never if the delay exceeds the timeout.
    initial forever begin
        @(negedge clk);
        io_rdata = io_resp_data;
        if (io_rd || io_wr) begin
            io_strobe_cnt++;
            if (io_strobe_cnt == 1) begin
                check("io_addr", {24'd0, io_addr}, {24'd0, exp_io_addr});
                check("io_dir", {31'd0, io_wr}, {31'd0, exp_io_wr});
                if (exp_io_wr) check("io_wdata", {24'd0, io_wdata}, {24'd0, exp_io_wdata});
            end
            io_ready = (io_strobe_cnt == io_delay);
        end else begin
            io_strobe_cnt = 0;
            io_ready      = 1'b0;
        end
    end

    // Interrupt acknowledge from the core, once, in a fixed cycle of the first run.
    initial forever begin
        @(negedge clk);
        intcycle_n = !(ack_enable && cyc == ACK_CYC);
    end

    // Monitor: cycle counter, interrupt model and scoreboard pops on each wait_n release.
    initial begin : monitor
        logic prev_wait;
        int   low_cnt, we_cnt, int_start, int_end;
        logic exp_int;
        prev_wait = 1'b1;
        low_cnt   = 0;
        we_cnt    = 0;
        int_start = 0;
        int_end   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                cyc = 0;
                int_start = 0;
                int_end   = 0;
                sb.delete();
                prev_wait = 1'b1;
                check("rst_wait_n", {31'd0, wait_n}, 32'd1);
                check("rst_int_n", {31'd0, int_n}, 32'd1);
                check("rst_di", {24'd0, di}, 32'hFF);
                check("rst_strobes", {29'd0, ram_we, io_rd, io_wr}, 32'd0);
            end else begin
                cyc++;
                if (cyc > int_start && cyc < int_end && intcycle_n == 1'b0) int_end = cyc;
                if (cyc % INT_PERIOD == 0 && !(cyc >= int_start && cyc < int_end)) begin
                    int_start = cyc;
                    int_end   = cyc + INT_WIDTH;
                end
                exp_int = !(cyc >= int_start && cyc < int_end);
                check("int_n", {31'd0, int_n}, {31'd0, exp_int});
                check("dinst", {24'd0, dinst}, {24'd0, di});

                if (!wait_n) begin
                    if (prev_wait) begin
                        low_cnt = 0;
                        we_cnt  = 0;
                    end
                    low_cnt++;
                    if (ram_we) we_cnt++;
                end else begin
                    if (ram_we) check("ram_we_idle", {31'd0, ram_we}, 32'd0);
                    if (!prev_wait) begin
                        if (sb.size() == 0) begin
                            check("sb_underflow", 32'd1, 32'd0);
                        end else begin
                            mon_e = sb.pop_front();
                            check({mon_e.name, "_di"}, {24'd0, di}, {24'd0, mon_e.di});
                            check({mon_e.name, "_wait"}, low_cnt, mon_e.low);
                            check({mon_e.name, "_we"}, we_cnt, mon_e.we);
                        end
                    end
                end
                prev_wait = wait_n;
            end
        end
    end

    // Issues one core cycle and returns once wait_n is released again.
    task automatic issue(input string name, input logic io, input logic wr, input logic [15:0] addr,
                         input logic [7:0] data, input int delay, input logic [7:0] io_data);
        exp_t e;
        logic is_rom, is_ram;
        int   guard;
        while (ack_enable && cyc == ACK_CYC) @(negedge clk);
        e.name = name;
        e.we   = 0;
        if (io) begin
            e.low        = (delay <= IO_TIMEOUT) ? delay + 1 : IO_TIMEOUT + 1;
            exp_io_addr  = addr[7:0];
            exp_io_wdata = data;
            exp_io_wr    = wr;
            io_delay     = delay;
            io_resp_data = io_data;
            if (!wr) model_di = (delay <= IO_TIMEOUT) ? io_data : 8'hFF;
        end else begin
            is_rom = ({16'd0, addr} < 32'd2 ** ROM_BITS);
            is_ram = !is_rom && addr[15];
            e.low  = 2 + (is_ram ? MEM_WAIT : 0);
            if (wr) begin
                if (is_ram) begin
                    ram_ref[addr[14:0]] = data;
                    e.we = 1;
                end
            end else begin
                model_di = is_rom ? rom_img[addr[ROM_BITS-1:0]] : (is_ram ? ram_ref[addr[14:0]] : 8'hFF);
            end
        end
        e.di = model_di;
        sb.push_back(e);
        ts = 7'b0000001; iorq = io; write = wr; no_read = wr; A = addr; dout = data;
        @(negedge clk);
        ts = 7'b0000010; iorq = 1'b0; write = 1'b0; no_read = 1'b1;
        guard = 0;
        while (wait_n == 1'b0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 60) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic random_traffic(input int n);
        logic [15:0] addr;
        for (int i = 0; i < n; i++) begin
            addr = ($urandom_range(0, 1) != 0 ? 16'h8000 : 16'hFFF0) | 16'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0: issue("rom_rd", 1'b0, 1'b0, 16'($urandom_range(0, 2047)), 8'd0, 0, 8'd0);
                1: issue("ram_rd", 1'b0, 1'b0, addr, 8'd0, 0, 8'd0);
                2: issue("ram_wr", 1'b0, 1'b1, addr, 8'($urandom), 0, 8'd0);
                3: issue("hole_rd", 1'b0, 1'b0, 16'($urandom_range(2048, 32767)), 8'd0, 0, 8'd0);
                4: issue("hole_wr", 1'b0, 1'b1, 16'($urandom_range(2048, 32767)), 8'($urandom), 0, 8'd0);
                5: issue("rom_wr", 1'b0, 1'b1, 16'($urandom_range(0, 2047)), 8'($urandom), 0, 8'd0);
                6: issue("io_rd", 1'b1, 1'b0, 16'($urandom), 8'd0, $urandom_range(1, 17), 8'($urandom));
                default: issue("io_wr", 1'b1, 1'b1, 16'($urandom), 8'($urandom), $urandom_range(1, 17), 8'd0);
            endcase
        end
    endtask

    initial begin : stimulus
        for (int i = 0; i < 2**ROM_BITS; i++) rom_img[i] = 8'($urandom);
        rom_img[5] = 8'h3E;
        for (int i = 0; i < 32768; i++) begin
            ram_env[i] = 8'(i) ^ 8'h5A;
            ram_ref[i] = 8'(i) ^ 8'h5A;
        end

        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue("rom_5", 1'b0, 1'b0, 16'h0005, 8'd0, 0, 8'd0);
        issue("ram_wr_8123", 1'b0, 1'b1, 16'h8123, 8'hA5, 0, 8'd0);
        issue("ram_rd_8123", 1'b0, 1'b0, 16'h8123, 8'd0, 0, 8'd0);
        issue("rom_top", 1'b0, 1'b0, 16'h07FF, 8'd0, 0, 8'd0);
        issue("hole_0800", 1'b0, 1'b0, 16'h0800, 8'd0, 0, 8'd0);
        issue("io_fe_ready", 1'b1, 1'b0, 16'h00FE, 8'd0, 3, 8'h1F);
        issue("io_fe_timeout", 1'b1, 1'b0, 16'h00FE, 8'd0, 40, 8'h1F);

        random_traffic(70);
        while (cyc < ACK_CYC + 20) @(negedge clk);
        ack_enable = 1'b0;

        // Abort a RAM read inside its wait phase.
        ts = 7'b0000001; iorq = 1'b0; write = 1'b0; no_read = 1'b0; A = 16'h8010;
        @(negedge clk);
        ts = 7'b0000010; no_read = 1'b1;
        @(negedge clk);
        reset    = 1'b1;
        model_di = 8'hFF;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue("rom_after_rst", 1'b0, 1'b0, 16'h0005, 8'd0, 0, 8'd0);
        random_traffic(45);

        repeat (5) @(negedge clk);
        check("sb_drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_bus_ctrl.md
# z80_bus_ctrl

Bus controller directly downstream of `tv80_core`. It consumes the core's cycle outputs (`ts`, `iorq`, `no_read`, `write`, `rfsh_n`, `intcycle_n`, `A`, `dout`) and turns each T1 into a ROM, RAM or I/O access. It returns read data on `di`/`dinst`, stretches cycles with `wait_n`, and generates the periodic frame interrupt on `int_n`.

## Interface
Parameters:
- `ROM_BITS`, 11: ROM occupies `0x0000 .. 2**ROM_BITS-1`.
- `MEM_WAIT`, 1: extra wait cycles per RAM access (0..7); ROM always uses 0.
- `IO_TIMEOUT`, 15: maximum cycles to wait for `io_ready`.
- `INT_PERIOD`, 40000: clocks between interrupt requests.
- `INT_WIDTH`, 64: maximum `int_n` low time in clocks.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ts` in 7: core T-state, one-hot; bit 0 = T1.
- `iorq`, `no_read`, `write`, `rfsh_n`, `intcycle_n` in 1 each: core cycle qualifiers.
- `A` in 16: address.
- `dout` in 8: core write data.
- `di`, `dinst` out 8 each: read data to the core, same registered value.
- `wait_n` out 1: wait request to the core, registered.
- `int_n` out 1: maskable interrupt, registered.
- `rom_addr` out `ROM_BITS`; `rom_rdata` in 8: synchronous ROM, 1-cycle latency.
- `ram_addr` out 15; `ram_we` out 1; `ram_wdata` out 8; `ram_rdata` in 8: synchronous RAM, 1-cycle latency.
- `io_addr` out 8; `io_rd`, `io_wr` out 1 each; `io_wdata` out 8; `io_rdata` in 8; `io_ready` in 1: I/O handshake.

## Operation
- Request detection: a request is a cycle with `ts[0]=1`, `rfsh_n=1` and `intcycle_n=1`. The block latches `A`, `dout` and the access kind:
  - I/O when `iorq=1`.
  - Write when `write=1`.
  - Read when `no_read=0` and `write=0`.
  - Otherwise no access.
- Decode:
  - ROM when `A < 2**ROM_BITS`.
  - RAM when `A[15]=1`, with `ram_addr = A[14:0]`.
  - Anything else is unmapped: reads return `0xFF`, writes are dropped.
  - ROM writes are dropped.
- FSM states: IDLE, MEM (memory data return), WAITCNT (RAM wait counting), IO (handshake), DONE (one cycle, `wait_n` released).
  - IDLE → MEM on a memory request.
  - IDLE → IO on an I/O request.
  - MEM → WAITCNT if the target is RAM and `MEM_WAIT>0`; otherwise MEM → DONE.
  - WAITCNT → DONE when the counter hits 0.
  - IO → DONE on `io_ready=1` or on timeout.
  - DONE → IDLE.
- `di` is loaded only when a read completes and holds its value otherwise.
- Reads on the unmapped region or on an I/O timeout load `0xFF`.
- Interrupt:
  - A free-running counter asserts `int_n=0` every `INT_PERIOD` clocks.
  - `int_n` returns high on the first cycle with `intcycle_n=0`, or after `INT_WIDTH` clocks, whichever comes first.
  - A new period starting while `int_n` is already low does not extend the pulse.
- Simultaneous events:
  - A request arriving while the FSM is not IDLE is ignored. The core cannot issue one, because `wait_n` is low.
  - Reset in any state returns the FSM to IDLE immediately, and drops any pending strobe and the in-flight write.

## Timing
- Reset values: `wait_n=1`, `int_n=1`, `di=dinst=0xFF`, `ram_we=io_rd=io_wr=0`, addresses and write data 0, interrupt counter 0.
- Request in cycle N:
  - Memory read: addresses are driven in cycle N+1 and data returns in N+2. W = `MEM_WAIT` for RAM and 0 for ROM. `di` is loaded at the end of N+2+W and valid from N+3+W. `wait_n` is low in N+1 .. N+2+W and high again in N+3+W.
  - RAM write: `ram_we=1` for exactly one cycle, N+1. `wait_n` follows the same timing as a RAM read.
  - I/O: `io_rd` or `io_wr` is high from N+1 until the cycle `io_ready` is sampled high, inclusive. `io_addr = A[7:0]`. `wait_n` stays low until that cycle. On timeout, the strobes drop after `IO_TIMEOUT` cycles.
- `int_n` first asserts at cycle `INT_PERIOD` after reset release. It stays low for at most `INT_WIDTH` cycles.
- Counter arithmetic: the interrupt counter is `$clog2(INT_PERIOD)` bits and wraps to 0 on reaching `INT_PERIOD-1`. The wait counter is 3 bits and the I/O timeout counter is 4 bits, both saturating.

## Structure
- Package `cobra_bus_pkg` holds:
  - FSM state enum (`BUS_IDLE`, `BUS_MEM`, `BUS_WAITCNT`, `BUS_IO`, `BUS_DONE`).
  - Access-kind enum (`ACC_NONE`, `ACC_RD`, `ACC_WR`).
  - Region enum (`REG_ROM`, `REG_RAM`, `REG_NONE`).
  - Constant `BUS_IDLE_DATA = 8'hFF`.
- One sub-module, `frame_int_gen`, contains the interrupt counter and the `int_n` pulse logic.

## Test plan
- Reset held high, then released: `wait_n=1`, `int_n=1`, `di=0xFF` on every cycle while reset is high.
- ROM read at `A=0x0005` with `rom_rdata=0x3E`: `wait_n` low for 2 cycles, `di=0x3E` from N+3.
- RAM write `0xA5` to `0x8123`, then a read of the same address, with `MEM_WAIT=2`:
  - write: `ram_addr=0x0123`, `ram_we` high one cycle, `wait_n` low 4 cycles;
  - read: returns `0xA5`.
- I/O read of port `0xFE` with `io_ready` arriving after 3 cycles and `io_rdata=0x1F`: `di=0x1F`. Repeat with `io_ready` held low: `di=0xFF` after 15 cycles.
- `INT_PERIOD=100`, `INT_WIDTH=10`: `int_n` falls at cycle 100.
  - With no acknowledge, it rises at cycle 110.
  - With `intcycle_n` pulsed low at cycle 104, it rises at cycle 105.
- Reset asserted mid-RAM-wait: the next cycle shows FSM IDLE, `wait_n=1`, `ram_we=0`, and a following ROM read behaves normally.
